// File: rtl/flow_led_pkg.sv
// Shared constants for the flow LED pattern generator.
// Optional PWM dimming is enabled by defining FLOWLED_PWM_EN.
package flow_led_pkg;

    localparam logic [1:0] MODE_SHL   = 2'd0;
    localparam logic [1:0] MODE_SHR   = 2'd1;
    localparam logic [1:0] MODE_PING  = 2'd2;
    localparam logic [1:0] MODE_BLINK = 2'd3;

    localparam logic DIR_UP = 1'b0;
    localparam logic DIR_DN = 1'b1;

    localparam int PWM_W = 4;

endpackage

// File: rtl/flow_led_ctrl_if.sv
// Control/status bundle between the LED generator and its driver.
// Master drives Enable/Mode/Bright; slave returns Step_Tick/LED_Out.
interface flow_led_ctrl_if #(
    parameter int N_LED = 4
) ();
    import flow_led_pkg::*;

    logic             Enable;
    logic [1:0]       Mode;
    logic [PWM_W-1:0] Bright;
    logic             Step_Tick;
    logic [N_LED-1:0] LED_Out;

    modport master (
        output Enable, Mode, Bright,
        input  Step_Tick, LED_Out
    );

    modport slave (
        input  Enable, Mode, Bright,
        output Step_Tick, LED_Out
    );

endinterface

// File: rtl/flow_led_tick.sv
// Step prescaler: counts 0..STEP_CYCLES-1 while enabled and
// flags the wrap cycle as a combinational tick.
module flow_led_tick #(
    parameter int STEP_CYCLES = 25_000_000,
    parameter int CNT_W       = 25
) (
    input  logic CLK,
    input  logic RSTn,
    input  logic Enable,
    output logic Tick
);

    localparam logic [CNT_W-1:0] c_last = CNT_W'(STEP_CYCLES - 1);

    logic [CNT_W-1:0] r_cnt;
    logic             w_wrap;

    assign w_wrap = (r_cnt == c_last);
    assign Tick   = Enable && w_wrap;

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            r_cnt <= '0;
        end else if (Enable) begin
            r_cnt <= w_wrap ? '0 : r_cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/flow_led_ctrl.sv
// N-channel LED pattern generator: shift, ping-pong and blink modes.
// Define FLOWLED_PWM_EN to add 4-bit PWM brightness gating.
module flow_led_ctrl #(
    parameter int N_LED       = 4,
    parameter int STEP_CYCLES = 25_000_000,
    parameter int CNT_W       = 25
) (
    input  logic           CLK,
    input  logic           RSTn,
    flow_led_ctrl_if.slave bus
);
    import flow_led_pkg::*;

    localparam logic [N_LED-1:0] c_one = N_LED'(1);
    localparam logic [N_LED-1:0] c_msb = c_one << (N_LED - 1);

    logic             w_tick;
    logic             w_gate;
    logic [N_LED-1:0] w_pat_nxt;
    logic             w_dir_nxt;

    logic [N_LED-1:0] r_pattern;
    logic             r_dir;
    logic [1:0]       r_mode;
    logic             r_step_tick;
    logic [N_LED-1:0] r_led;

    flow_led_tick #(
        .STEP_CYCLES(STEP_CYCLES),
        .CNT_W      (CNT_W)
    ) u_tick (
        .CLK   (CLK),
        .RSTn  (RSTn),
        .Enable(bus.Enable),
        .Tick  (w_tick)
    );

    always_comb begin
        w_pat_nxt = r_pattern;
        w_dir_nxt = r_dir;
        if (bus.Mode != r_mode) begin
            // A mode change only re-seeds; the first move comes next tick.
            w_dir_nxt = DIR_UP;
            case (bus.Mode)
                MODE_SHR:   w_pat_nxt = c_msb;
                MODE_BLINK: w_pat_nxt = '1;
                default:    w_pat_nxt = c_one;
            endcase
        end else begin
            case (r_mode)
                MODE_SHL:
                    w_pat_nxt = (r_pattern << 1) | (r_pattern >> (N_LED - 1));
                MODE_SHR:
                    w_pat_nxt = (r_pattern >> 1) | (r_pattern << (N_LED - 1));
                MODE_PING: begin
                    if (N_LED > 1) begin
                        if (r_dir == DIR_UP) begin
                            if (r_pattern[N_LED-1]) begin
                                w_pat_nxt = r_pattern >> 1;
                                w_dir_nxt = DIR_DN;
                            end else begin
                                w_pat_nxt = r_pattern << 1;
                            end
                        end else begin
                            if (r_pattern[0]) begin
                                w_pat_nxt = r_pattern << 1;
                                w_dir_nxt = DIR_UP;
                            end else begin
                                w_pat_nxt = r_pattern >> 1;
                            end
                        end
                    end
                end
                default:
                    w_pat_nxt = ~r_pattern;
            endcase
        end
    end

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            r_pattern   <= c_one;
            r_dir       <= DIR_UP;
            r_mode      <= MODE_SHL;
            r_step_tick <= 1'b0;
            r_led       <= '0;
        end else begin
            r_step_tick <= w_tick;
            r_led       <= r_pattern & {N_LED{w_gate}};
            if (w_tick) begin
                r_pattern <= w_pat_nxt;
                r_dir     <= w_dir_nxt;
                r_mode    <= bus.Mode;
            end
        end
    end

`ifdef FLOWLED_PWM_EN
    logic [PWM_W-1:0] r_pwm_cnt;
    logic [PWM_W-1:0] r_bright;

    // Brightness is only taken at the period start so duty never glitches.
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            r_pwm_cnt <= '0;
            r_bright  <= '0;
        end else begin
            r_pwm_cnt <= r_pwm_cnt + PWM_W'(1);
            if (r_pwm_cnt == '0) r_bright <= bus.Bright;
        end
    end

    assign w_gate = (r_pwm_cnt < r_bright);
`else
    logic w_unused;

    assign w_gate   = 1'b1;
    assign w_unused = ^bus.Bright;
`endif

    assign bus.Step_Tick = r_step_tick;
    assign bus.LED_Out   = r_led;

endmodule

// File: tb/tb_flow_led_ctrl.sv
// Directed bench for flow_led_ctrl with N_LED=4, STEP_CYCLES=4.
// Under FLOWLED_PWM_EN the LED samples are ORed over two cycles.
module tb_flow_led_ctrl;
    import flow_led_pkg::*;

`ifdef FLOWLED_PWM_EN
    localparam bit PWM_ON = 1'b1;
    localparam int GAP    = 2;
`else
    localparam bit PWM_ON = 1'b0;
    localparam int GAP    = 3;
`endif

    logic CLK;
    logic RSTn;
    int   n_tests;
    int   n_fail;

    flow_led_ctrl_if #(.N_LED(4)) bus ();

    flow_led_ctrl #(
        .N_LED      (4),
        .STEP_CYCLES(4),
        .CNT_W      (2)
    ) u_dut (
        .CLK (CLK),
        .RSTn(RSTn),
        .bus (bus)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] act,
                       input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h want %0h", tag, act, exp);
        end
    endtask

    function automatic bit led_ok(input logic [3:0] act,
                                  input logic [3:0] exp);
        return (act == exp) || (PWM_ON && act == 4'h0);
    endfunction

    task automatic get_led(output logic [3:0] led);
        led = bus.LED_Out;
        if (PWM_ON) begin
            @(negedge CLK);
            led = led | bus.LED_Out;
        end
    endtask

    // Waits for the Step_Tick pulse, then checks gap, pulse width and LEDs.
    task automatic step(input string tag, input logic [3:0] exp_led,
                        input int exp_n);
        int         n;
        logic [3:0] led;
        n = 0;
        do begin
            @(negedge CLK);
            n++;
        end while (!bus.Step_Tick && n < 20);
        chk({tag, "_tick"}, 32'(bus.Step_Tick), 32'd1);
        if (exp_n > 0) chk({tag, "_gap"}, 32'(n), 32'(exp_n));
        @(negedge CLK);
        chk({tag, "_pulse"}, 32'(bus.Step_Tick), 32'd0);
        get_led(led);
        chk(tag, 32'(led), 32'(exp_led));
    endtask

    task automatic count_lit(output int lit);
        lit = 0;
        for (int i = 0; i < 16; i++) begin
            @(negedge CLK);
            if (bus.LED_Out == 4'hF) lit++;
        end
    endtask

    logic [3:0] led;
    logic [3:0] ping_exp [8];
    bit         frz_bad;
    int         lit;

    initial begin
        n_tests = 0;
        n_fail  = 0;
        ping_exp = '{4'h1, 4'h2, 4'h4, 4'h8, 4'h4, 4'h2, 4'h1, 4'h2};

        RSTn       = 1'b0;
        bus.Enable = 1'b1;
        bus.Mode   = MODE_SHL;
        bus.Bright = 4'hF;
        repeat (3) @(negedge CLK);
        chk("rst_led", 32'(bus.LED_Out), 32'h0);
        chk("rst_tick", 32'(bus.Step_Tick), 32'h0);

        RSTn = 1'b1;
        @(negedge CLK);
        get_led(led);
        chk("init_led", 32'(led), 32'h1);

        step("shl1", 4'h2, GAP);
        step("shl2", 4'h4, GAP);
        step("shl3", 4'h8, GAP);
        step("shl4", 4'h1, GAP);

        bus.Mode = MODE_PING;
        for (int i = 0; i < 8; i++)
            step($sformatf("ping%0d", i), ping_exp[i], GAP);

        bus.Mode = MODE_SHL;
        step("shl_init", 4'h1, GAP);
        step("shl_go", 4'h2, GAP);
        @(negedge CLK);
        bus.Mode = MODE_SHR;
        step("shr_init", 4'h8, -1);
        step("shr_go", 4'h4, GAP);

        bus.Enable = 1'b0;
        frz_bad = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge CLK);
            if (bus.Step_Tick || !led_ok(bus.LED_Out, 4'h4)) frz_bad = 1'b1;
        end
        chk("freeze", 32'(frz_bad), 32'd0);
        bus.Enable = 1'b1;
        step("resume", 4'h2, GAP);

        bus.Mode = MODE_BLINK;
        step("blink0", 4'hF, GAP);
        step("blink1", 4'h0, GAP);
        step("blink2", 4'hF, GAP);
        @(negedge CLK);
        RSTn = 1'b0;
        #1;
        chk("arst_led", 32'(bus.LED_Out), 32'h0);
        chk("arst_tick", 32'(bus.Step_Tick), 32'h0);
        @(negedge CLK);
        RSTn = 1'b1;
        @(negedge CLK);
        get_led(led);
        chk("arst_init", 32'(led), 32'h1);
        step("arst_step", 4'hF, GAP);

        bus.Enable = 1'b0;
`ifdef FLOWLED_PWM_EN
        bus.Bright = 4'd4;
        repeat (20) @(negedge CLK);
        count_lit(lit);
        chk("pwm_b4", 32'(lit), 32'd4);
        bus.Bright = 4'd0;
        repeat (20) @(negedge CLK);
        count_lit(lit);
        chk("pwm_b0", 32'(lit), 32'd0);
`else
        bus.Bright = 4'd0;
        repeat (20) @(negedge CLK);
        count_lit(lit);
        chk("no_pwm", 32'(lit), 32'd16);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
